stopwatch_bcd: RTL and testbench

- Four-digit decimal stopwatch (SSS.t, tenths resolution) for the board's 7-segment display path.
- Debounces two push-buttons, runs an IDLE/RUN/PAUSE control FSM and a prescaled BCD counter cascade.
- Drives four BCD nibbles plus active-low decimal-point enables straight into the per-digit hex-to-7-segment decoders, whose outputs go to the 4-digit scan multiplexer.

---
 rtl/stopwatch_bcd.sv | 190 +++++++++++++++++++
 tb/tb_stopwatch_bcd.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_bcd
// Brief    : Four-digit BCD stopwatch (SSS.t) with debounced start/stop and
//            clear buttons, IDLE/RUN/PAUSE control and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_bcd #(
  parameter int TICK_DIV  = 5000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_go,
  input  logic       btn_clr,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [3:0] dp_n,
  output logic       running,
  output logic       ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0] C_PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] C_DB_MAX    = DW'(DB_CYCLES - 1);
  localparam logic [3:0]    C_DP_N      = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  logic [1:0] btn_raw;
  logic [1:0] press_p;
  logic       go_p;
  logic       clr_p;

  assign btn_raw = {btn_clr, btn_go};

  // One conditioner per button: bit 0 = go, bit 1 = clear.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic          s1_q, s1_d, s2_q, s2_d;
    logic          db_q, db_d, prev_q, prev_d;
    logic          pulse_q, pulse_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Synchronize, require DB_CYCLES of consistent disagreement, then flag a rising level.
    always_comb begin
      s1_d    = btn_raw[b];
      s2_d    = s1_q;
      db_d    = db_q;
      cnt_d   = '0;
      prev_d  = db_q;
      pulse_d = db_q & ~prev_q;
      if (s2_q != db_q) begin
        if (cnt_q == C_DB_MAX) begin
          db_d = s2_q;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
    end

    // Conditioner state; reset restarts debouncing from a released level.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        db_q    <= 1'b0;
        prev_q  <= 1'b0;
        pulse_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        s1_q    <= s1_d;
        s2_q    <= s2_d;
        db_q    <= db_d;
        prev_q  <= prev_d;
        pulse_q <= pulse_d;
        cnt_q   <= cnt_d;
      end
    end

    assign press_p[b] = pulse_q;
  end

  assign go_p  = press_p[0];
  assign clr_p = press_p[1];

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0][3:0] dig_q, dig_d, dig_inc;
  logic            ovf_q, ovf_d;
  logic            running_q, running_d;
  logic            tick;
  logic            all9;

  assign tick = (state_q == S_RUN) && (presc_q == C_PRESC_MAX);
  assign all9 = (dig_q == 16'h9999);

  // Ripple a +1 through the four decimal digits, lowest digit first.
  always_comb begin
    logic carry;
    carry   = 1'b1;
    dig_inc = dig_q;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig_q[i] == 4'd9) begin
          dig_inc[i] = 4'd0;
        end else begin
          dig_inc[i] = dig_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  // Control FSM plus prescaler, digit and overflow updates; clear overrides everything.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    if (clr_p) begin
      state_d = S_IDLE;
      presc_d = '0;
      dig_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_p) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          if (tick) begin
            presc_d = '0;
            if (all9) begin
              ovf_d   = 1'b1;
              state_d = S_PAUSE;
            end else begin
              dig_d = dig_inc;
              if (go_p) state_d = S_PAUSE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
            if (go_p) state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (go_p && !ovf_q) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
    running_d = (state_d == S_RUN);
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      dig_q     <= '0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dig_q     <= dig_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
    end
  end

  assign d3      = dig_q[3];
  assign d2      = dig_q[2];
  assign d1      = dig_q[1];
  assign d0      = dig_q[0];
  assign dp_n    = C_DP_N;
  assign running = running_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_bcd
// Brief    : Randomized bench for stopwatch_bcd against a behavioural model
//            that keeps elapsed time as a plain integer count of tenths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_bcd;

  localparam int TICK_DIV  = 4;
  localparam int DB_CYCLES = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_go = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] d3, d2, d1, d0, dp_n;
  logic       running, ovf;

  int n_vec = 0;
  int n_err = 0;

  stopwatch_bcd #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk(clk), .reset(reset), .btn_go(btn_go), .btn_clr(btn_clr),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0), .dp_n(dp_n),
    .running(running), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Buttons: the raw level is seen two edges late; the accepted level flips
  // once the seen level has disagreed with it for DB_CYCLES edges in a row;
  // a press is reported on the edge after the accepted level rose.
  int m_seen1[2], m_seen2[2], m_disagree[2], m_level[2], m_level_old[2], m_press[2];
  int m_st;      // 0 idle, 1 run, 2 pause
  int m_phase;   // cycles into current tenth
  int m_cnt;     // elapsed tenths, 0..9999
  bit m_ovf;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_seen1[b] = 0; m_seen2[b] = 0; m_disagree[b] = 0;
      m_level[b] = 0; m_level_old[b] = 0; m_press[b] = 0;
    end
    m_st = 0; m_phase = 0; m_cnt = 0; m_ovf = 1'b0;
  endfunction

  task automatic model_step();
    int  raw[2];
    int  new_press;
    bit  go, clr, tick;
    raw[0] = int'(btn_go);
    raw[1] = int'(btn_clr);
    go  = (m_press[0] != 0);
    clr = (m_press[1] != 0);
    for (int b = 0; b < 2; b++) begin
      new_press      = (m_level[b] == 1 && m_level_old[b] == 0) ? 1 : 0;
      m_level_old[b] = m_level[b];
      if (m_seen2[b] != m_level[b]) begin
        m_disagree[b]++;
        if (m_disagree[b] == DB_CYCLES) begin
          m_level[b]    = m_seen2[b];
          m_disagree[b] = 0;
        end
      end else begin
        m_disagree[b] = 0;
      end
      m_seen2[b] = m_seen1[b];
      m_seen1[b] = raw[b];
      m_press[b] = new_press;
    end
    tick = (m_st == 1) && (m_phase == TICK_DIV - 1);
    if (clr) begin
      m_st = 0; m_phase = 0; m_cnt = 0; m_ovf = 1'b0;
    end else if (m_st == 0) begin
      if (go) begin m_st = 1; m_phase = 0; end
    end else if (m_st == 1) begin
      if (tick) begin
        m_phase = 0;
        if (m_cnt == 9999) begin
          m_ovf = 1'b1; m_st = 2;
        end else begin
          m_cnt++;
          if (go) m_st = 2;
        end
      end else begin
        m_phase++;
        if (go) m_st = 2;
      end
    end else begin
      if (go && !m_ovf) m_st = 1;
    end
  endtask

  always @(posedge clk) begin
    if (!reset) model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check_all();
    chk("digits", {16'h0, d3, d2, d1, d0}, {16'h0, to_bcd(m_cnt)});
    chk("flags", {26'h0, dp_n, running, ovf}, {26'h0, 4'b1101, 1'(m_st == 1), m_ovf});
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic g, input logic c);
    @(negedge clk);
    check_all();
    btn_go  = g;
    btn_clr = c;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic press(input logic g, input logic c, input bit bounce, input int hold);
    if (bounce) begin
      step(g, c); step(1'b0, 1'b0); step(g, c); step(1'b0, 1'b0);
    end
    repeat (hold) step(g, c);
    idle(DB_CYCLES + 4);
  endtask

  task automatic run_until(input int target, input int budget);
    int k = 0;
    while (m_cnt != target && k < budget) begin
      step(1'b0, 1'b0);
      k++;
    end
    chk("reach", {16'h0, d3, d2, d1, d0}, {16'h0, to_bcd(target)});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;

    // quiet after reset
    idle(100);

    // bounced go press, count past the first digit rollover
    press(1'b1, 1'b0, 1'b1, 10);
    run_until(10, 400);

    // clear, run to 25, pause, hold, resume
    press(1'b0, 1'b1, 1'b0, DB_CYCLES + 1);
    press(1'b1, 1'b0, 1'b0, DB_CYCLES);
    run_until(25, 400);
    press(1'b1, 1'b0, 1'b0, DB_CYCLES);
    idle(50);
    press(1'b1, 1'b0, 1'b0, DB_CYCLES);
    idle(40);

    // go and clear together while running
    press(1'b1, 1'b1, 1'b0, DB_CYCLES + 2);
    idle(20);

    // randomized button activity
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: idle($urandom_range(1, 30));
        1: press(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(DB_CYCLES, DB_CYCLES + 6));
        2: press(1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(DB_CYCLES, DB_CYCLES + 6));
        3: press(1'b1, 1'b1, 1'b0, $urandom_range(DB_CYCLES, DB_CYCLES + 6));
        4: begin
          repeat ($urandom_range(1, DB_CYCLES - 1)) step(1'b1, 1'b0);
          idle(6);
        end
        default: idle($urandom_range(20, 60));
      endcase
    end

    // asynchronous reset in the middle of a count at 0137
    press(1'b0, 1'b1, 1'b0, DB_CYCLES + 1);
    press(1'b1, 1'b0, 1'b0, DB_CYCLES);
    run_until(137, 1000);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    idle(2);
    reset = 1'b0;
    idle(30);
    press(1'b1, 1'b0, 1'b0, DB_CYCLES);
    idle(30);

    // clear, run the full range into overflow
    press(1'b0, 1'b1, 1'b0, DB_CYCLES + 1);
    press(1'b1, 1'b0, 1'b0, DB_CYCLES);
    run_until(9999, 45000);
    idle(3 * TICK_DIV);
    chk("ovf_set", {31'h0, ovf}, 32'h1);
    press(1'b1, 1'b0, 1'b0, DB_CYCLES);
    idle(20);
    press(1'b0, 1'b1, 1'b0, DB_CYCLES);
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
